// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM stage: instruction field helpers,
// opcode constants, bypass select encodings and handshake FSM states.
package ex_mem_stage_pkg;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam logic SEL_LOAD_BYPASS = 1'b1;
  localparam logic SEL_ALU_PATH    = 1'b0;

  typedef enum logic {
    MEM_RUN    = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic [5:0] insn_op(input logic [31:0] insn);
    return insn[31:26];
  endfunction

  function automatic logic is_mem_op(input logic [31:0] insn);
    return (insn_op(insn) == OP_LW) || (insn_op(insn) == OP_SW);
  endfunction

endpackage

// File: rtl/ex_mem_stage_mem_handshake_fsm.sv
// Data-memory req/ack handshake: tracks the outstanding access, counts wait
// cycles, and raises the pipeline stall or the timeout-abort pulse.
module mem_handshake_fsm
  import ex_mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic next_is_mem,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic mem_err
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  logic             advance;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (advance) begin
      state_d = next_is_mem ? MEM_ACCESS : MEM_RUN;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Ack beats timeout: a completing access never reports an error.
  always_comb begin
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT));
    dmem_req    = (state_q == MEM_ACCESS);
    mem_stall   = dmem_req && !dmem_ack && !timeout_hit;
    mem_err     = dmem_req && !dmem_ack && timeout_hit;
    advance     = !mem_stall;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM and MEM/WB pipeline registers with store-data load bypass; the
// data-memory handshake lives in mem_handshake_fsm.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = 32'h0000_0000,
  parameter int          TIMEOUT  = 15,
  parameter int          CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IRex,
  input  logic [31:0] ALUout_ex,
  input  logic [31:0] SMDR_ex,
  input  logic        SMDRsel,
  input  logic        flush_ex,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] IRmem,
  output logic [31:0] ALUout_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] IRwb,
  output logic [31:0] ALUout_wb,
  output logic [31:0] LMD,
  output logic        mem_stall,
  output logic        mem_err
);

  logic [31:0] ir_mem_q, ir_mem_d;
  logic [31:0] alu_mem_q, alu_mem_d;
  logic [31:0] smdr_mem_q, smdr_mem_d;
  logic [31:0] ir_wb_q, ir_wb_d;
  logic [31:0] alu_wb_q, alu_wb_d;
  logic [31:0] lmd_q, lmd_d;
  logic [31:0] ir_mem_next;

  assign ir_mem_next = flush_ex ? NOP_INSN : IRex;

  mem_handshake_fsm #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_is_mem (is_mem_op(ir_mem_next)),
    .dmem_ack    (dmem_ack),
    .dmem_req    (dmem_req),
    .mem_stall   (mem_stall),
    .mem_err     (mem_err)
  );

  // The bypass is only selected while an LW in MEM completes this cycle,
  // so dmem_rdata is the forwarded load value at that edge.
  always_comb begin
    ir_mem_d   = ir_mem_q;
    alu_mem_d  = alu_mem_q;
    smdr_mem_d = smdr_mem_q;
    ir_wb_d    = NOP_INSN;
    alu_wb_d   = '0;
    lmd_d      = lmd_q;
    if (!mem_stall) begin
      ir_mem_d   = ir_mem_next;
      alu_mem_d  = ALUout_ex;
      smdr_mem_d = (SMDRsel == SEL_LOAD_BYPASS) ? dmem_rdata : SMDR_ex;
      ir_wb_d    = ir_mem_q;
      alu_wb_d   = alu_mem_q;
      if (insn_op(ir_mem_q) == OP_LW) begin
        lmd_d = dmem_ack ? dmem_rdata : 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_mem_q   <= NOP_INSN;
      alu_mem_q  <= '0;
      smdr_mem_q <= '0;
      ir_wb_q    <= NOP_INSN;
      alu_wb_q   <= '0;
      lmd_q      <= '0;
    end else begin
      ir_mem_q   <= ir_mem_d;
      alu_mem_q  <= alu_mem_d;
      smdr_mem_q <= smdr_mem_d;
      ir_wb_q    <= ir_wb_d;
      alu_wb_q   <= alu_wb_d;
      lmd_q      <= lmd_d;
    end
  end

  assign IRmem      = ir_mem_q;
  assign ALUout_mem = alu_mem_q;
  assign dmem_addr  = alu_mem_q;
  assign dmem_wdata = smdr_mem_q;
  assign dmem_we    = dmem_req && (insn_op(ir_mem_q) == OP_SW);
  assign IRwb       = ir_wb_q;
  assign ALUout_wb  = alu_wb_q;
  assign LMD        = lmd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: load bypass, delayed ack, timeout abort,
// flush, reset during an access, and r0 store data.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] LW_R5  = 32'h8C25_0000;  // LW  r5,0(r1)
  localparam logic [31:0] SW_R5  = 32'hAC25_0004;  // SW  r5,4(r1)
  localparam logic [31:0] ADD_I  = 32'h0022_1820;  // ADD r3,r1,r2
  localparam logic [31:0] LW_R0  = 32'h8C20_0000;  // LW  r0,0(r1)
  localparam logic [31:0] SW_R0  = 32'hAC40_0008;  // SW  r0,8(r2)

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IRex, ALUout_ex, SMDR_ex, dmem_rdata;
  logic        SMDRsel, flush_ex, dmem_ack;
  logic [31:0] IRmem, ALUout_mem, dmem_addr, dmem_wdata, IRwb, ALUout_wb, LMD;
  logic        dmem_req, dmem_we, mem_stall, mem_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IRex       (IRex),
    .ALUout_ex  (ALUout_ex),
    .SMDR_ex    (SMDR_ex),
    .SMDRsel    (SMDRsel),
    .flush_ex   (flush_ex),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .IRmem      (IRmem),
    .ALUout_mem (ALUout_mem),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .IRwb       (IRwb),
    .ALUout_wb  (ALUout_wb),
    .LMD        (LMD),
    .mem_stall  (mem_stall),
    .mem_err    (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] smdr,
                       input logic sel, input logic flush, input logic ack,
                       input logic [31:0] rdata);
    IRex       = ir;
    ALUout_ex  = alu;
    SMDR_ex    = smdr;
    SMDRsel    = sel;
    flush_ex   = flush;
    dmem_ack   = ack;
    dmem_rdata = rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_cnt;
    int req_cycles;
    int err_cnt;
    int err_cycle;
    logic stalled;

    rst_n = 1'b0;
    drive(NOP, 32'h0, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    #12;
    check("rst_irmem", IRmem, NOP);
    check("rst_irwb", IRwb, NOP);
    check("rst_lmd", LMD, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_err", 32'(mem_err), 32'h0);
    tick;
    rst_n = 1'b1;

    // LW then SW with load bypass, ack on the same cycle
    drive(LW_R5, 32'h100, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    check("t1_req_lw", 32'(dmem_req), 32'h1);
    drive(SW_R5, 32'h104, 32'h1111_1111, SEL_LOAD_BYPASS, 1'b0, 1'b1, 32'hCAFE_0001);
    #1;
    check("t1_nostall_lw", 32'(mem_stall), 32'h0);
    check("t1_we_lw", 32'(dmem_we), 32'h0);
    tick;
    check("t1_wdata_bypass", dmem_wdata, 32'hCAFE_0001);
    check("t1_lmd", LMD, 32'hCAFE_0001);
    check("t1_irwb", IRwb, LW_R5);
    check("t1_addr", dmem_addr, 32'h104);
    check("t1_we_sw", 32'(dmem_we), 32'h1);
    drive(NOP, 32'h0, 32'h0, SEL_ALU_PATH, 1'b0, 1'b1, 32'h0);
    #1;
    check("t1_nostall_sw", 32'(mem_stall), 32'h0);
    tick;
    check("t1_req_done", 32'(dmem_req), 32'h0);
    check("t1_irwb_sw", IRwb, SW_R5);
    check("t1_aluwb", ALUout_wb, 32'h104);

    // LW with ack delayed three cycles
    drive(LW_R5, 32'h200, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    drive(ADD_I, 32'h2A, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_stall) stall_cnt++;
      tick;
      check("t2_irwb_bubble", IRwb, NOP);
      check("t2_aluwb_bubble", ALUout_wb, 32'h0);
      check("t2_irmem_hold", IRmem, LW_R5);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_0003;
    #1;
    check("t2_stall_cycles", 32'(stall_cnt), 32'd3);
    check("t2_stall_released", 32'(mem_stall), 32'h0);
    tick;
    check("t2_lmd", LMD, 32'hDEAD_0003);
    check("t2_irwb_lw", IRwb, LW_R5);
    check("t2_irmem_next", IRmem, ADD_I);
    dmem_ack = 1'b0;

    // SW that is never acknowledged: timeout abort
    drive(SW_R5, 32'h300, 32'h55, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    drive(ADD_I, 32'h2B, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    req_cycles = 0;
    err_cnt    = 0;
    err_cycle  = 0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (dmem_req) req_cycles++;
      if (mem_err) begin
        err_cnt++;
        err_cycle = i;
      end
      stalled = mem_stall;
      tick;
      if (!stalled) break;
    end
    check("t3_req_cycles", 32'(req_cycles), 32'd16);
    check("t3_err_count", 32'(err_cnt), 32'd1);
    check("t3_err_cycle", 32'(err_cycle), 32'd16);
    check("t3_req_dropped", 32'(dmem_req), 32'h0);
    check("t3_err_cleared", 32'(mem_err), 32'h0);
    check("t3_irmem", IRmem, ADD_I);
    check("t3_irwb", IRwb, SW_R5);
    check("t3_lmd_kept", LMD, 32'hDEAD_0003);
    // counter must have restarted: a fresh LW stalls without an error
    drive(LW_R5, 32'h500, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    drive(NOP, 32'h0, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    #1;
    check("t3_cnt_reset_stall", 32'(mem_stall), 32'h1);
    check("t3_cnt_reset_err", 32'(mem_err), 32'h0);
    tick;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    tick;
    check("t3_lmd_after", LMD, 32'h0BAD_F00D);
    dmem_ack = 1'b0;

    // flush of an ADD in EX
    drive(ADD_I, 32'h3, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    check("t4_irmem_add", IRmem, ADD_I);
    drive(ADD_I, 32'h4, 32'h0, SEL_ALU_PATH, 1'b1, 1'b0, 32'h0);
    tick;
    check("t4_irmem_flushed", IRmem, NOP);
    check("t4_irwb_add", IRwb, ADD_I);
    drive(ADD_I, 32'h5, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    check("t4_irwb_nop", IRwb, NOP);

    // reset during an access after two wait cycles
    drive(LW_R5, 32'h600, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    drive(NOP, 32'h0, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    tick;
    check("t5_pre_stall", 32'(mem_stall), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_req", 32'(dmem_req), 32'h0);
    check("t5_err", 32'(mem_err), 32'h0);
    check("t5_stall", 32'(mem_stall), 32'h0);
    check("t5_irmem", IRmem, NOP);
    check("t5_addr", dmem_addr, 32'h0);
    check("t5_lmd", LMD, 32'h0);
    #3;
    rst_n = 1'b1;
    tick;
    drive(ADD_I, 32'h77, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    check("t5_first_insn", IRmem, ADD_I);
    check("t5_first_alu", ALUout_mem, 32'h77);
    check("t5_no_req", 32'(dmem_req), 32'h0);

    // SW r0 after LW r0: ALU-path store data, not the returning load data
    drive(LW_R0, 32'h700, 32'h0, SEL_ALU_PATH, 1'b0, 1'b0, 32'h0);
    tick;
    drive(SW_R0, 32'h708, 32'h0, SEL_ALU_PATH, 1'b0, 1'b1, 32'h1234_5678);
    #1;
    check("t6_nostall", 32'(mem_stall), 32'h0);
    tick;
    check("t6_wdata_r0", dmem_wdata, 32'h0);
    check("t6_lmd", LMD, 32'h1234_5678);
    check("t6_we", 32'(dmem_we), 32'h1);
    check("t6_addr", dmem_addr, 32'h708);
    drive(NOP, 32'h0, 32'h0, SEL_ALU_PATH, 1'b0, 1'b1, 32'h0);
    tick;
    check("t6_req_done", 32'(dmem_req), 32'h0);
    check("t6_irwb", IRwb, SW_R0);
    dmem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register and data-memory access controller for the MIPS-Lite pipeline.
- Latches the EX-stage instruction, ALU result and store data into the MEM stage.
- Consumes SMDRsel from the EX bypass unit to pick store data: ALU path, or the load data returning from MEM.
- Runs a req/ack handshake to data memory, stalls the pipe while an access is outstanding, and feeds the WB latch.

Parameters:
- NOP_INSN, 32'h00000000, encoding inserted on reset, flush and bubbles.
- TIMEOUT, 15, maximum wait cycles for dmem_ack before the access is aborted.
- CNT_W, 4, width of the wait counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IRex  in  32  EX-stage instruction.
- ALUout_ex  in  32  EX result; effective address for LW/SW.
- SMDR_ex  in  32  store data via the ALU path (rt value).
- SMDRsel  in  1  `select_load_bypass / `select_ALU_path, from the EX bypass unit.
- flush_ex  in  1  squash the EX instruction at the next advance.
- dmem_ack  in  1  memory completes the current access this cycle.
- dmem_rdata  in  32  read data, valid when dmem_ack=1.
- IRmem  out  32  MEM-stage instruction register.
- ALUout_mem  out  32  MEM-stage address/result.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  equals ALUout_mem.
- dmem_wdata  out  32  registered store data (SMDR_mem).
- IRwb  out  32  WB-stage instruction.
- ALUout_wb  out  32  WB ALU result.
- LMD  out  32  load data for WB.
- mem_stall  out  1  hold IF/ID/EX this cycle.
- mem_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, rst_n=0):
  - IRmem = IRwb = NOP_INSN.
  - ALUout_mem, SMDR_mem, ALUout_wb, LMD = 0.
  - State = RUN, counter = 0, mem_err = 0.
- is_mem = (IRmem[`op]==`LW) || (IRmem[`op]==`SW).
- Outputs that are combinational from state and inputs:
  - dmem_req = (state==ACCESS).
  - dmem_we = dmem_req && IRmem[`op]==`SW.
  - mem_stall = dmem_req && !dmem_ack && !timeout_hit, where timeout_hit = (cnt==TIMEOUT).
- advance = !mem_stall. On each rising edge with advance=1:
  - IRmem <= flush_ex ? NOP_INSN : IRex.
  - ALUout_mem <= ALUout_ex.
  - SMDR_mem <= (SMDRsel==`select_load_bypass) ? dmem_rdata : SMDR_ex.
  - IRwb <= IRmem; ALUout_wb <= ALUout_mem.
  - LMD <= (IRmem[`op]==`LW) ? (dmem_ack ? dmem_rdata : 32'h0) : LMD.
- Load bypass: SMDRsel can only select the bypass when IRmem is an LW completing on this cycle. dmem_rdata at that edge is the forwarded value. Zero added latency.
- On edges with mem_stall=1:
  - IRmem, ALUout_mem and SMDR_mem hold.
  - IRwb <= NOP_INSN (bubble); ALUout_wb <= 0.
  - flush_ex is ignored; upstream holds it.
- FSM, evaluated on next-IRmem at each advance:
  - RUN -> ACCESS when the newly latched IRmem is LW/SW; otherwise stay RUN.
  - ACCESS, dmem_ack=1 -> advance; next state chosen by the incoming instruction (ACCESS again for back-to-back memory ops); cnt <= 0.
  - ACCESS, no ack, cnt<TIMEOUT -> hold; cnt <= cnt+1.
  - ACCESS, cnt==TIMEOUT without ack -> mem_err=1 for that cycle; advance with LMD=0; cnt <= 0.
- Ack and timeout on the same cycle: ack wins, mem_err=0.
- Reset mid-ACCESS: immediate return to RUN, request dropped, no mem_err.
- A store whose rt is r0 always stores the ALU-path value, which is 0. SMDRsel is never bypass in that case; no extra check here.

Decomposition:
- dlx_defs.v carries `op, `rt, `LW, `SW, `r0, `select_load_bypass, `select_ALU_path, plus new state encodings `MEM_RUN / `MEM_ACCESS.
- One sub-module is natural: mem_handshake_fsm. It holds state, cnt, timeout_hit, dmem_req and mem_stall generation.
- The pipeline registers stay in ex_mem_stage.

Test Plan:
- LW r5,0(r1) then SW r5,4(r1), SMDRsel=bypass, ack same cycle with rdata=32'hCAFE0001:
  - The store's dmem_wdata = 32'hCAFE0001 one cycle later.
  - No stall cycles.
- LW with dmem_ack delayed 3 cycles:
  - mem_stall high exactly 3 cycles; IRwb = NOP for those 3 edges.
  - LMD = rdata after ack; IRmem stable throughout.
- SW with no ack ever:
  - dmem_req high for TIMEOUT+1 cycles; mem_err pulses once on cycle 16.
  - Pipe then advances; cnt returns to 0.
- ADD in EX with flush_ex=1, no stall:
  - IRmem = NOP_INSN next cycle; IRwb = NOP one cycle after.
- rst_n low during ACCESS after 2 wait cycles:
  - Outputs return to reset values asynchronously; dmem_req=0; mem_err=0.
  - First instruction after release latches normally.
- SW r0,8(r2) after LW r0, ack same cycle, SMDRsel=ALU path:
  - dmem_wdata = SMDR_ex value (0), not rdata.
